// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer: shift-add multiply and restoring divide over WIDTH cycles.
// Optional MULDIV_SIGNED_EN selects two's-complement operands; undefined builds are unsigned only.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_DIV = 4'b0100;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             busy_q, done_q;

  logic             sel_div, accept, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;

  assign sel_div = (sel == SEL_DIV);
  assign accept  = (state_q == IDLE) && start && ((sel == SEL_MUL) || sel_div);
  assign b_zero  = (op_b == '0);

`ifdef MULDIV_SIGNED_EN
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [2*WIDTH-1:0] prod;

  assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;

  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    if (div_q) begin
      fin_lo = neg_q  ? -step_lo : step_lo;
      fin_hi = rneg_q ? -step_hi : step_hi;
    end else begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
  end
`else
  assign a_mag  = op_a;
  assign b_mag  = op_b;
  assign fin_hi = step_hi;
  assign fin_lo = step_lo;
`endif

  // One iteration step; opd_q is the multiplicand for MUL and the divisor for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, opd_q};
    div_ge    = div_sh[WIDTH] | ~div_trial[WIDTH];
    if (div_q) begin
      step_hi = div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    opd_d    = opd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
`ifdef MULDIV_SIGNED_EN
    neg_d    = neg_q;
    rneg_d   = rneg_q;
`endif
    if (accept) begin
      cnt_d    = CNT_INIT;
      div_d    = sel_div;
      dz_d     = sel_div & b_zero;
      opd_d    = sel_div ? b_mag : a_mag;
      acc_hi_d = '0;
      acc_lo_d = sel_div ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
      neg_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
      rneg_d   = op_a[WIDTH-1];
`endif
      if (sel_div && b_zero) begin
        lo_d = '1;
        hi_d = op_a;
      end
    end else if (state_q == CALC) begin
      cnt_d    = cnt_q - 1'b1;
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
      if (cnt_q == CW'(1)) begin
        hi_d = fin_hi;
        lo_d = fin_lo;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (sel_div && b_zero) ? DONE : CALC;
      CALC: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      opd_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      opd_q    <= opd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
`ifdef MULDIV_SIGNED_EN
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  always_comb begin
    stall = (state_q == CALC) || accept;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes model results, negedge monitor pops on done.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_DIV = 4'b0100;

  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] sel;
  logic [W-1:0] op_a, op_b, hi, lo;
  logic stall, busy, done, div_zero;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .op_a(op_a), .op_b(op_b),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: plain arithmetic on the full operands.
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    int sa, sb;
    longint pl;
    sa = a;
    sb = b;
`endif
    e.cyc = 0;
    e.dz  = 1'b0;
    if (s == SEL_MUL) begin
`ifdef MULDIV_SIGNED_EN
      pl = longint'(sa) * longint'(sb);
      p  = pl;
`else
      p = {32'd0, a} * {32'd0, b};
`endif
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
      e.dz = 1'b1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      e.lo = sa / sb;
      e.hi = sa % sb;
`else
      e.lo = a / b;
      e.hi = a % b;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual hi=%h lo=%h required=no done", hi, lo);
      end else begin
        e = q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", div_zero, e.dz);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_done", busy, 1);
        chk("stall_in_done", stall, 0);
      end
    end
  end

  task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_t e;
    int stalls;
    bit seen;
    bit dz;
    dz = (s == SEL_DIV) && (b == 0);
    @(negedge clk);
    chk("hold_hi", hi, last.hi);
    chk("hold_lo", lo, last.lo);
    chk("hold_dz", div_zero, last.dz);
    start = 1'b1; sel = s; op_a = a; op_b = b;
    #1;
    chk("stall_accept", stall, 1);
    e = model(s, a, b);
    e.cyc = cyc + (dz ? 1 : W + 1);
    q.push_back(e);
    last = e;
    stalls = 1;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (stall === 1'b1) stalls++;
      if (n == 0) begin
        chk("busy_after_accept", busy, 1);
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
      end
      if (poke && n == 5) begin start = 1'b1; sel = SEL_MUL; end
      if (poke && n == 6) start = 1'b0;
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no done required=done within 60 cycles");
    end
    chk("stall_cycles", stalls, dz ? 1 : W + 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 4'b0; op_a = '0; op_b = '0;
    last = '{hi: 0, lo: 0, dz: 0, cyc: 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", div_zero, 0);

    foreach (last.hi[i]) if (i < 3) begin
      logic [3:0] codes [3] = '{4'b0010, 4'b1111, 4'b0101};
      @(negedge clk);
      start = 1'b1; sel = codes[i]; op_a = $urandom; op_b = $urandom;
      #1;
      chk("other_sel_stall", stall, 0);
      @(negedge clk);
      chk("other_sel_busy", busy, 0);
      chk("other_sel_hi", hi, last.hi);
      start = 1'b0;
    end

    issue(SEL_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    issue(SEL_DIV, 32'd100, 32'd7, 1'b0);
`ifdef MULDIV_SIGNED_EN
    issue(SEL_DIV, -32'sd100, 32'd7, 1'b0);
`endif
    issue(SEL_DIV, 32'h1234, 32'h0, 1'b0);
    issue(SEL_MUL, 32'd12, 32'd13, 1'b0);
    issue(SEL_MUL, $urandom, $urandom, 1'b1);

    @(negedge clk);
    start = 1'b1; sel = SEL_MUL; op_a = $urandom; op_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_dz", div_zero, 0);
    chk("midrst_stall", stall, 0);
    last = '{hi: 0, lo: 0, dz: 0, cyc: 0};
    repeat (40) @(negedge clk);
    issue(SEL_MUL, 32'd3, 32'd5, 1'b0);

    repeat (40) begin
      logic [3:0] s;
      logic [31:0] a, b;
      s = ($urandom % 2) ? SEL_MUL : SEL_DIV;
      a = ($urandom % 4 == 0) ? ($urandom % 1024) : $urandom;
      case ($urandom % 6)
        0: b = 32'd0;
        1, 2: b = $urandom % 256;
        default: b = $urandom;
      endcase
      issue(s, a, b, ($urandom % 4) == 0);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expected actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the MUL and DIV operations selected by the ALU control decoder. It captures operands when a multiply or divide is issued and runs an iterative shift-add multiply or restoring divide over WIDTH cycles. It stalls the core while busy and returns a HI/LO result pair with a one-cycle done pulse. It sits beside the ALU in the execute stage; the ALU keeps handling every other select code.

## Interface
- WIDTH, 32, operand and result width; the iteration counter is clog2(WIDTH)+1 bits
- clk  input  1  rising-edge clock, sole clock of the block
- rst  input  1  synchronous, active-high reset
- start  input  1  issue request, sampled only in IDLE
- sel  input  4  ALU select; 4'b0011 = MUL, 4'b0100 = DIV, all other codes ignored
- op_a  input  WIDTH  multiplicand / dividend
- op_b  input  WIDTH  multiplier / divisor
- stall  output  1  combinational; holds the pipeline
- busy  output  1  registered; high in CALC and DONE
- done  output  1  registered; one-cycle pulse when results become valid
- hi  output  WIDTH  MUL: upper product half; DIV: remainder
- lo  output  WIDTH  MUL: lower product half; DIV: quotient
- div_zero  output  1  set by a DIV with op_b = 0, cleared by the next accepted start

## Operation
- States: IDLE, CALC, DONE.
- Accept: the block is in IDLE, start = 1 and sel is MUL or DIV. It latches op_a and op_b, loads the counter with WIDTH, records the operation and clears div_zero.
  - Normal case: go to CALC.
  - DIV with op_b = 0: go to DONE directly with lo = all ones, hi = op_a, div_zero = 1.
- start with any other sel code: no state change and no output change.
- MUL in CALC: each cycle examines the LSB of the multiplier register. If it is 1, add the multiplicand to the upper accumulator half using a WIDTH+1 bit add, keeping the carry. Then shift the {carry, acc_hi, acc_lo} register right by 1 and decrement the counter.
- DIV in CALC: each cycle shifts {rem, quo} left by 1 and computes trial = rem - divisor using a WIDTH+1 bit subtract.
  - trial is non-negative: rem = trial and the quotient LSB is 1.
  - trial is negative: rem is kept and the quotient LSB is 0.
- CALC to DONE: when the counter reaches 1, write hi and lo, then go to DONE.
- DONE: done = 1 for exactly that cycle, then return to IDLE.
- hi, lo and div_zero hold their values until the next accepted start, so they stay readable after done.
- start in CALC or DONE is ignored; no queuing.
- rst in any state, including mid-CALC: return to IDLE and drop the partial result.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, stall = 0, hi = 0, lo = 0, div_zero = 0.
- stall = (state == CALC) | (state == IDLE & start & sel in {MUL, DIV}).
- stall is high in the accept cycle and through every CALC cycle. It is low in DONE, so the consuming instruction advances in that cycle.
- Accept at edge N: CALC occupies cycles N+1 through N+WIDTH. DONE is cycle N+WIDTH+1, with done = 1 and hi/lo valid. With WIDTH = 32, DONE is 33 cycles after accept.
- Divide by zero: DONE is cycle N+1.
- Back-to-back: the earliest next accept is the cycle after DONE, when the block is back in IDLE.

## Configuration
- MULDIV_SIGNED_EN
  - Defined: operands are two's complement.
    - At accept, op_a and op_b are replaced by their magnitudes and two sign flags are stored.
    - MUL: the 2*WIDTH product is negated at CALC exit if the operand signs differ.
    - DIV: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
    - Latency is unchanged. Divide by zero still gives lo = all ones and hi = op_a unmodified.
  - Undefined: all operands are unsigned and no sign logic is synthesized.

## Test plan
- Reset: assert rst for 2 cycles -> all outputs 0, state IDLE, stall = 0 with start = 0.
- MUL unsigned: op_a = 32'hFFFF_FFFF, op_b = 32'h0000_0002, sel = 0011 -> done 33 cycles after accept, hi = 32'h1, lo = 32'hFFFF_FFFE, stall high for 33 cycles (accept cycle plus 32 CALC).
- DIV: op_a = 100, op_b = 7, sel = 0100 -> lo = 14, hi = 2, div_zero = 0; with MULDIV_SIGNED_EN, op_a = -100, op_b = 7 -> lo = -14, hi = -2.
- Divide by zero: op_a = 32'h1234, op_b = 0 -> done 1 cycle after accept, lo = 32'hFFFF_FFFF, hi = 32'h1234, div_zero = 1; a following MUL accept clears div_zero.
- Non-mul/div select and start while busy: start with sel = 0010 -> no state change, stall = 0; start pulsed mid-CALC -> ignored, first result unchanged.
- Reset mid-operation: rst at CALC cycle 10 -> IDLE next cycle, done never pulses, hi = lo = 0; a fresh MUL of 3 x 5 completes with lo = 15.
